div_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for 16-bit division in the MIPS ALU.
- Accepts a dividend/divisor pair through a start/busy/valid handshake.
- Runs a restoring shift-subtract loop, one quotient bit per clock.
- Returns the result in the same packed QR format the ALU already uses: quotient in [31:16], remainder in [15:0]. This bounds per-cycle logic to one subtractor instead of an unbounded combinational loop.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_seq_ctrl_if.sv | 24 ++
 rtl/div_step.sv | 23 ++
 rtl/div_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Start/busy/valid handshake bundle between an ALU requester and the divider.
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               valid;
  logic               dz;
  logic [2*WIDTH-1:0] QR;

  modport master (
    output start, A, B,
    input  busy, valid, dz, QR
  );

  modport slave (
    input  start, A, B,
    output busy, valid, dz, QR
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH-2:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // rem's MSB is always zero before a shift, since it holds fewer than WIDTH dividend bits
  always_comb begin
    shifted    = {rem, quo_msb};
    trial      = {1'b0, shifted} - {1'b0, divisor};
    q_bit_c    = ~trial[WIDTH];
    rem_next_c = q_bit_c ? trial[WIDTH-1:0] : shifted;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider returning {quotient, remainder} in QR.
// Define DIV_SEQ_SIGNED_EN for two's complement operands (truncating division).
module div_seq_ctrl #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH,
  parameter int unsigned CNT_W = div_pkg::DIV_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  div_seq_ctrl_if.slave bus
);

  import div_pkg::*;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   rem_q, rem_nx;
  logic [WIDTH-1:0]   quo_q, quo_nx;
  logic [WIDTH-1:0]   dvs_q, dvs_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic               dzp_q, dzp_nx;
  logic               busy_nx, valid_nx, dz_nx;
  logic [2*WIDTH-1:0] qr_nx;
  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   a_load, b_load;

`ifdef DIV_SEQ_SIGNED_EN
  logic a_neg_q, a_neg_nx;
  logic q_neg_q, q_neg_nx;

  // Iterate on magnitudes; signs are re-applied when QR is loaded
  always_comb begin
    a_load = bus.A[WIDTH-1] ? WIDTH'(-bus.A) : bus.A;
    b_load = bus.B[WIDTH-1] ? WIDTH'(-bus.B) : bus.B;
    q_fix  = q_neg_q ? WIDTH'(-quo_q) : quo_q;
    r_fix  = a_neg_q ? WIDTH'(-rem_q) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
    end else begin
      a_neg_q <= a_neg_nx;
      q_neg_q <= q_neg_nx;
    end
  end
`else
  always_comb begin
    a_load = bus.A;
    b_load = bus.B;
    q_fix  = quo_q;
    r_fix  = rem_q;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q[WIDTH-2:0]),
    .quo_msb    (quo_q[WIDTH-1]),
    .divisor    (dvs_q),
    .rem_next_c (step_rem),
    .q_bit_c    (step_bit)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      dzp_q     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.dz    <= 1'b0;
      bus.QR    <= '0;
    end else begin
      state     <= state_nx;
      rem_q     <= rem_nx;
      quo_q     <= quo_nx;
      dvs_q     <= dvs_nx;
      cnt_q     <= cnt_nx;
      dzp_q     <= dzp_nx;
      bus.busy  <= busy_nx;
      bus.valid <= valid_nx;
      bus.dz    <= dz_nx;
      bus.QR    <= qr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem_q;
    quo_nx   = quo_q;
    dvs_nx   = dvs_q;
    cnt_nx   = cnt_q;
    dzp_nx   = dzp_q;
    busy_nx  = 1'b0;
    valid_nx = 1'b0;
    dz_nx    = bus.dz;
    qr_nx    = bus.QR;
`ifdef DIV_SEQ_SIGNED_EN
    a_neg_nx = a_neg_q;
    q_neg_nx = q_neg_q;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          dz_nx  = 1'b0;
          rem_nx = '0;
          dvs_nx = b_load;
          cnt_nx = CNT_W'(WIDTH);
`ifdef DIV_SEQ_SIGNED_EN
          a_neg_nx = bus.A[WIDTH-1];
          q_neg_nx = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
          if (bus.B == '0) begin
            // Raw dividend is kept so the zero-divisor result can echo it
            quo_nx   = bus.A;
            dzp_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            quo_nx   = a_load;
            dzp_nx   = 1'b0;
            busy_nx  = 1'b1;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        rem_nx  = step_rem;
        quo_nx  = {quo_q[WIDTH-2:0], step_bit};
        cnt_nx  = cnt_q - CNT_W'(1);
        busy_nx = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_nx  = 1'b0;
          state_nx = DONE;
        end
      end
      DONE: begin
        valid_nx = 1'b1;
        dz_nx    = dzp_q;
        qr_nx    = dzp_q ? {WIDTH'(DZ_QUOTIENT), quo_q} : {q_fix, r_fix};
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl; expected results come from plain-arithmetic division.
// Honours DIV_SEQ_SIGNED_EN the same way as the design.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  typedef struct {
    logic [2*W-1:0] qr;
    logic           dz;
    int             due;
    string          name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: integer division from the operand values, no iteration
  function automatic logic [2*W-1:0] ref_qr(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) return {{W{1'b1}}, a};
`ifdef DIV_SEQ_SIGNED_EN
    begin
      int sa, sd;
      sa = int'($signed(a));
      sd = int'($signed(b));
      q  = W'(sa / sd);
      r  = W'(sa % sd);
    end
`else
    q = a / b;
    r = a % b;
`endif
    return {q, r};
  endfunction

  // Monitor: pop and compare on every valid pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(bus.QR), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_qr"}, 64'(bus.QR), 64'(e.qr));
          chk({e.name, "_dz"}, 64'(bus.dz), 64'(e.dz));
          chk({e.name, "_latency"}, 64'(edge_cnt), 64'(e.due));
        end
      end
    end
  end

  // Drive one request for a single cycle; the DUT is idle when called
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input string nm,
                       output int due);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    due    = edge_cnt + ((b == '0) ? 1 : W + 1);
    e.qr   = ref_qr(a, b);
    e.dz   = (b == '0);
    e.due  = due;
    e.name = nm;
    sb.push_back(e);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    chk({nm, "_busy"}, 64'(bus.busy), 64'(b != '0));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    chk({nm, "_valid_pulse"}, 64'(bus.valid), 64'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    int due;
    issue(a, b, nm, due);
    wait_done(nm);
  endtask

  initial begin
    int due1, n;
    exp_t e;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    #2;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_valid", 64'(bus.valid), 64'd0);
    chk("reset_dz", 64'(bus.dz), 64'd0);
    chk("reset_qr", 64'(bus.QR), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'd100, 16'd7, "d100_7");
    chk("d100_7_const", 64'(bus.QR), 64'h000E_0002);
    run(16'd5, 16'd0, "dz5");
    chk("dz5_const", 64'(bus.QR), 64'hFFFF_0005);
    repeat (3) @(negedge clk);
    chk("dz_held", 64'(bus.dz), 64'd1);
    run(16'd3, 16'd10, "d3_10");
    chk("dz_cleared", 64'(bus.dz), 64'd0);
    run(16'hFFFF, 16'd1, "dffff_1");
    run(16'hFFFF, 16'hFFFF, "dffff_ffff");
    run(16'hFFFE, 16'hFFFF, "dfffe_ffff");

    // Start held through BUSY and DONE: only the IDLE cycle after valid may accept it
    issue(16'd100, 16'd7, "hold_first", due1);
    bus.start = 1'b1;
    bus.A     = 16'd9;
    bus.B     = 16'd3;
    n = 0;
    while (edge_cnt < due1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e.qr   = ref_qr(16'd9, 16'd3);
    e.dz   = 1'b0;
    e.due  = due1 + 1 + W + 1;
    e.name = "hold_second";
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("hold");
    chk("hold_second_const", 64'(bus.QR), 64'h0003_0000);

    // Asynchronous abort mid-division
    issue(16'd100, 16'd7, "abort", due1);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.valid), 64'd0);
    chk("abort_dz", 64'(bus.dz), 64'd0);
    chk("abort_qr", 64'(bus.QR), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run(16'd20, 16'd6, "d20_6");
    chk("d20_6_const", 64'(bus.QR), 64'h0003_0002);

`ifdef DIV_SEQ_SIGNED_EN
    run(16'hFFF9, 16'd2, "s_m7_2");
    chk("s_m7_2_const", 64'(bus.QR), 64'hFFFD_FFFF);
    run(16'h8000, 16'hFFFF, "s_ovf");
    chk("s_ovf_const", 64'(bus.QR), 64'h8000_0000);
    run(16'd7, 16'hFFFE, "s_7_m2");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a + W'($urandom_range(1, 100));
        default: b = W'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(a, b, "rand");
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
